mux_arbiter: RTL

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
// Two-requester arbiter with burst limits feeding a registered shared path.
// Per-bit Multiplexer cells steer DATA_A/DATA_B under SEL.
module multiplexer (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_A,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic             LAST_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] DATA_B,
    input  logic             LAST_B,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             SEL,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_VALID
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             prio;
    logic             prio_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             sel_q;
    logic             sel_n;
    logic             xfer;
    logic             rel;
    logic [WIDTH-1:0] mux_out;

    // Both requesting: p=0 favours A, p=1 favours B.
    function automatic state_t pick(input logic ra, input logic rb, input logic p);
        if (ra && rb) return p ? OWN_B : OWN_A;
        if (ra) return OWN_A;
        if (rb) return OWN_B;
        return IDLE;
    endfunction

    always_comb begin
        state_n = state;
        prio_n  = prio;
        cnt_n   = cnt;
        xfer    = 1'b0;
        rel     = 1'b0;
        unique case (state)
            IDLE: state_n = pick(REQ_A, REQ_B, prio);
            OWN_A: begin
                xfer = REQ_A;
                rel  = !REQ_A || LAST_A || (cnt == CNT_MAX && REQ_B);
                if (rel) begin
                    prio_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = pick(REQ_A, REQ_B, 1'b1);
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            OWN_B: begin
                xfer = REQ_B;
                rel  = !REQ_B || LAST_B || (cnt == CNT_MAX && REQ_A);
                if (rel) begin
                    prio_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = pick(REQ_A, REQ_B, 1'b0);
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // SEL follows the owner and keeps its last value through IDLE.
    always_comb begin
        sel_n = sel_q;
        if (state_n == OWN_A) sel_n = 1'b0;
        if (state_n == OWN_B) sel_n = 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        multiplexer u_mux (
            .a  (DATA_A[i]),
            .b  (DATA_B[i]),
            .sel(sel_q),
            .y  (mux_out[i])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            prio      <= 1'b0;
            cnt       <= '0;
            sel_q     <= 1'b0;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            state     <= state_n;
            prio      <= prio_n;
            cnt       <= cnt_n;
            sel_q     <= sel_n;
            OUT_VALID <= xfer;
            if (xfer) OUT <= mux_out;
        end
    end

    assign GNT_A = (state == OWN_A);
    assign GNT_B = (state == OWN_B);
    assign SEL   = sel_q;
endmodule
